// File: rtl/period_avg_if.sv
// Bundle between the upstream ramp counter, period_avg and the readout logic.
// slave : the averaging block (consumes cnt/clr, produces the result stream)
// master: the environment (drives cnt/clr and ready, observes the result)
interface period_avg_if #(
  parameter int W = 5
);
  logic [W-1:0] cnt_i;
  logic         clr_n_i;
  logic [W-1:0] avg_o;
  logic         avg_valid_o;
  logic         avg_ready_i;
  logic         wrap_o;
  logic         ovr_o;
  logic [W-1:0] min_o;
  logic [W-1:0] max_o;

  modport slave (
    input  cnt_i, clr_n_i, avg_ready_i,
    output avg_o, avg_valid_o, wrap_o, ovr_o, min_o, max_o
  );

  modport master (
    output cnt_i, clr_n_i, avg_ready_i,
    input  avg_o, avg_valid_o, wrap_o, ovr_o, min_o, max_o
  );
endinterface

// File: rtl/period_avg.sv
// period_avg: recovers the final count of each upstream ramp period, averages
// 2^LOG2_N periods and hands the result out on a valid/ready stream.
// Flags counter wrap within a window (wrap_o) and dropped results (ovr_o).
// Optional macro PERIOD_AVG_MINMAX_EN adds per-window min/max of the samples;
// without it min_o/max_o are tied to 0.
module period_avg #(
  parameter int W      = 5,
  parameter int LOG2_N = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  period_avg_if.slave bus
);

  typedef enum logic {SYNC, ACC} state_t;

  state_t              state_q;
  logic [W-1:0]        cnt_q;
  logic                clr_q;
  logic [W+LOG2_N-1:0] sum_q;
  logic [W+LOG2_N-1:0] sum_d;
  logic [LOG2_N-1:0]   idx_q;
  logic                pwrap_q;
  logic                wacc_q;
  logic [W-1:0]        avg_q;
  logic [W-1:0]        avg_d;
  logic                valid_q;
  logic                wrap_q;
  logic                ovr_q;

  logic                period_ev;
  logic                wrap_ev;
  logic                last;
  logic                acc_ev;
  logic                issue;
  logic                load;
  logic [W-1:0]        sample;

  // Event detection, sample selection and window arithmetic
  always_comb begin
    period_ev = clr_q & ~bus.clr_n_i;
    wrap_ev   = bus.clr_n_i & (cnt_q == '1) & (bus.cnt_i == '0);
    // A wrapped period saturates: its sample is the full-scale count.
    sample    = pwrap_q ? '1 : cnt_q;
    sum_d     = sum_q + {{LOG2_N{1'b0}}, sample};
    avg_d     = sum_d[W+LOG2_N-1:LOG2_N];
    last      = (idx_q == '1);
    acc_ev    = en & (state_q == ACC) & period_ev;
    issue     = acc_ev & last;
    load      = issue & (~valid_q | bus.avg_ready_i);
  end

  // FSM, accumulator and registered result/handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      clr_q   <= 1'b1;
      sum_q   <= '0;
      idx_q   <= '0;
      pwrap_q <= 1'b0;
      wacc_q  <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q <= bus.cnt_i;
      clr_q <= bus.clr_n_i;

      // Transfer retires the held result; a same-edge load below re-asserts.
      if (valid_q && bus.avg_ready_i) valid_q <= 1'b0;

      if (!en) begin
        state_q <= SYNC;
        sum_q   <= '0;
        idx_q   <= '0;
        pwrap_q <= 1'b0;
        wacc_q  <= 1'b0;
      end else begin
        if (wrap_ev) pwrap_q <= 1'b1;
        case (state_q)
          SYNC: begin
            if (period_ev) begin
              state_q <= ACC;
              sum_q   <= '0;
              idx_q   <= '0;
              pwrap_q <= 1'b0;
              wacc_q  <= 1'b0;
            end
          end
          ACC: begin
            if (period_ev) begin
              pwrap_q <= 1'b0;
              if (last) begin
                sum_q  <= '0;
                idx_q  <= '0;
                wacc_q <= 1'b0;
                if (load) begin
                  avg_q   <= avg_d;
                  wrap_q  <= wacc_q | pwrap_q;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end else begin
                sum_q  <= sum_d;
                idx_q  <= idx_q + LOG2_N'(1);
                wacc_q <= wacc_q | pwrap_q;
              end
            end
          end
          default: state_q <= SYNC;
        endcase
      end
    end
  end

  assign bus.avg_o       = avg_q;
  assign bus.avg_valid_o = valid_q;
  assign bus.wrap_o      = wrap_q;
  assign bus.ovr_o       = ovr_q;

`ifdef PERIOD_AVG_MINMAX_EN
  logic [W-1:0] min_acc_q;
  logic [W-1:0] max_acc_q;
  logic [W-1:0] min_d;
  logic [W-1:0] max_d;
  logic [W-1:0] min_q;
  logic [W-1:0] max_q;

  // Running window extremes; the first sample of a window seeds both
  always_comb begin
    min_d = sample;
    max_d = sample;
    if (idx_q != '0) begin
      if (min_acc_q < sample) min_d = min_acc_q;
      if (max_acc_q > sample) max_d = max_acc_q;
    end
  end

  // Extremes follow the same load/hold rules as the average
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_acc_q <= '0;
      max_acc_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      if (acc_ev) begin
        min_acc_q <= min_d;
        max_acc_q <= max_d;
      end
      if (load) begin
        min_q <= min_d;
        max_q <= max_d;
      end
    end
  end

  assign bus.min_o = min_q;
  assign bus.max_o = max_q;
`else
  assign bus.min_o = '0;
  assign bus.max_o = '0;
`endif

endmodule

// File: tb/tb_period_avg.sv
// Bench for period_avg: directed scenarios followed by randomized ramp
// periods, ready and occasional en/reset, compared every cycle against a
// window-queue reference model.
module tb_period_avg;
  localparam int W      = 5;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int FULL   = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  period_avg_if #(.W(W)) bus ();

  period_avg #(.W(W), .LOG2_N(LOG2_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_sync   = 1'b1;
  bit prev_clr = 1'b1;
  int m_samp[$];
  bit m_wr[$];
  int e_avg = 0, e_min = 0, e_max = 0;
  bit e_valid = 1'b0, e_wrap = 1'b0, e_ovr = 1'b0;
  int pend_sample = 0;
  bit pend_wrap   = 1'b0;
  bit rand_mode   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive upstream count/strobe, advance the model, compare.
  task automatic step(input int c, input bit cl);
    bit ev, done, xfer, w;
    int s, mn, mx;
    if (rand_mode) begin
      bus.avg_ready_i = ($urandom_range(0, 3) != 0);
      en              = ($urandom_range(0, 149) != 0);
      rst_n           = ($urandom_range(0, 399) != 0);
    end
    bus.cnt_i   = W'(c);
    bus.clr_n_i = cl;
    @(posedge clk);
    if (!rst_n) begin
      m_sync = 1'b1; prev_clr = 1'b1;
      m_samp.delete(); m_wr.delete();
      e_avg = 0; e_min = 0; e_max = 0;
      e_valid = 1'b0; e_wrap = 1'b0; e_ovr = 1'b0;
    end else begin
      ev = prev_clr && !cl;
      prev_clr = cl;
      done = 1'b0; s = 0; mn = 0; mx = 0; w = 1'b0;
      if (!en) begin
        m_sync = 1'b1;
        m_samp.delete(); m_wr.delete();
      end else if (ev) begin
        if (m_sync) begin
          m_sync = 1'b0;
        end else begin
          m_samp.push_back(pend_sample);
          m_wr.push_back(pend_wrap);
          if (m_samp.size() == N) begin
            mn = m_samp[0]; mx = m_samp[0];
            foreach (m_samp[i]) begin
              s += m_samp[i];
              w |= m_wr[i];
              if (m_samp[i] < mn) mn = m_samp[i];
              if (m_samp[i] > mx) mx = m_samp[i];
            end
            m_samp.delete(); m_wr.delete();
            done = 1'b1;
          end
        end
      end
      xfer = e_valid && bus.avg_ready_i;
      if (done && (!e_valid || xfer)) begin
        e_avg = s >> LOG2_N; e_wrap = w; e_valid = 1'b1;
`ifdef PERIOD_AVG_MINMAX_EN
        e_min = mn; e_max = mx;
`else
        e_min = 0; e_max = 0;
`endif
      end else if (done) begin
        e_ovr = 1'b1;
      end else if (xfer) begin
        e_valid = 1'b0;
      end
    end
    #1;
    check("valid", 32'(bus.avg_valid_o), 32'(e_valid));
    check("ovr", 32'(bus.ovr_o), 32'(e_ovr));
    if (e_valid) begin
      check("avg", 32'(bus.avg_o), 32'(e_avg));
      check("wrap", 32'(bus.wrap_o), 32'(e_wrap));
      check("min", 32'(bus.min_o), 32'(e_min));
      check("max", 32'(bus.max_o), 32'(e_max));
    end
  endtask

  // Upstream ramp reaching final count p (p > FULL means it wrapped), then
  // cleared; hold adds extra cycles with the strobe still low.
  task automatic period(input int p, input int hold);
    for (int k = 1; k <= p; k++) step(k % (1 << W), 1'b1);
    pend_sample = (p > FULL) ? FULL : p;
    pend_wrap   = (p > FULL);
    step(0, 1'b0);
    for (int h = 0; h < hold; h++) step(0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 1'b1);
    step(0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int p, hold;
    bus.cnt_i = '0;
    bus.clr_n_i = 1'b1;
    bus.avg_ready_i = 1'b1;

    // reset state
    do_reset();
    check("rst_avg", 32'(bus.avg_o), 32'd0);
    check("rst_valid", 32'(bus.avg_valid_o), 32'd0);
    check("rst_wrap", 32'(bus.wrap_o), 32'd0);
    check("rst_ovr", 32'(bus.ovr_o), 32'd0);
    check("rst_min", 32'(bus.min_o), 32'd0);
    check("rst_max", 32'(bus.max_o), 32'd0);

    // basic window: first period discarded, 52>>2
    en = 1'b1;
    period(10, 0); period(10, 0); period(12, 0); period(14, 0); period(16, 0);
    check("t1_valid", 32'(bus.avg_valid_o), 32'd1);
    check("t1_avg", 32'(bus.avg_o), 32'd13);
    check("t1_wrap", 32'(bus.wrap_o), 32'd0);

    // held result with consumer stalled, two windows dropped
    do_reset();
    en = 1'b1;
    bus.avg_ready_i = 1'b0;
    period(10, 0); period(10, 0); period(12, 0); period(14, 0); period(16, 0);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < N; j++) period(8, 0);
      check("t2_hold_avg", 32'(bus.avg_o), 32'd13);
      check("t2_ovr", 32'(bus.ovr_o), 32'd1);
    end
    bus.avg_ready_i = 1'b1;
    step(1, 1'b1);
    check("t2_drop_valid", 32'(bus.avg_valid_o), 32'd0);

    // wrapped period saturates at full scale
    period(35, 0); period(20, 0); period(20, 0); period(20, 0);
    check("t3_avg", 32'(bus.avg_o), 32'd22);
    check("t3_wrap", 32'(bus.wrap_o), 32'd1);

    // reset mid-window
    period(5, 0); period(5, 0);
    rst_n = 1'b0;
    step(1, 1'b1);
    rst_n = 1'b1;
    check("t4_rst_valid", 32'(bus.avg_valid_o), 32'd0);
    check("t4_rst_ovr", 32'(bus.ovr_o), 32'd0);
    period(9, 0); period(4, 1); period(4, 0); period(4, 2);
    check("t4_not_yet", 32'(bus.avg_valid_o), 32'd0);
    period(6, 0);
    check("t4_avg", 32'(bus.avg_o), 32'd4);

    // enable dropped mid-window
    period(6, 0); period(6, 0);
    en = 1'b0;
    period(3, 0);
    en = 1'b1;
    period(10, 0); period(1, 0); period(2, 0); period(3, 0);
    check("t5_not_yet", 32'(bus.avg_valid_o), 32'd0);
    period(4, 0);
    check("t5_avg", 32'(bus.avg_o), 32'd2);

    // window extremes
    period(5, 0); period(9, 0); period(7, 0); period(6, 0);
    check("t6_avg", 32'(bus.avg_o), 32'd6);
`ifdef PERIOD_AVG_MINMAX_EN
    check("t6_min", 32'(bus.min_o), 32'd5);
    check("t6_max", 32'(bus.max_o), 32'd9);
`else
    check("t6_min", 32'(bus.min_o), 32'd0);
    check("t6_max", 32'(bus.max_o), 32'd0);
`endif

    // randomized periods, ready, enable and reset
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      p    = $urandom_range(1, 40);
      hold = $urandom_range(0, 2);
      period(p, hold);
    end
    rand_mode = 1'b0;
    rst_n = 1'b1;
    en = 1'b1;
    bus.avg_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
